// File: rtl/vram_arb_pkg.sv
// Shared encodings for the VRAM arbiter: FSM states, read-tag layout and owner codes.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DSP  = 2'd1,
    ST_HST  = 2'd2
  } arb_st_e;

  localparam int TAG_W    = 3;
  localparam int TAG_VLD  = 2;
  localparam int TAG_OWN  = 1;
  localparam int TAG_LAST = 0;

  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_DISP = 1'b1;

  function automatic logic [TAG_W-1:0] mk_tag(input logic vld, input logic own, input logic last);
    logic [TAG_W-1:0] t;
    t           = {TAG_W{1'b0}};
    t[TAG_VLD]  = vld;
    t[TAG_OWN]  = own;
    t[TAG_LAST] = last;
    return t;
  endfunction

endpackage

// File: rtl/vram_rtag.sv
// Read-tag delay line: carries (valid, owner, last) of each issued access so the
// flags line up with vr_rdat RD_LAT cycles later.
module vram_rtag
  import vram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic [TAG_W-1:0] tag_in,
  output logic             vld,
  output logic             own,
  output logic             last
);

  logic [TAG_W-1:0] pipe_r [RD_LAT];

  // Shift the tag one stage per cycle.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < RD_LAT; i++) pipe_r[i] <= {TAG_W{1'b0}};
    end else begin
      pipe_r[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign vld  = pipe_r[RD_LAT-1][TAG_VLD];
  assign own  = pipe_r[RD_LAT-1][TAG_OWN];
  assign last = pipe_r[RD_LAT-1][TAG_LAST];

endmodule

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter between host byte accesses and display line bursts.
// Display has priority; a host slot is inserted after HOST_GAP consecutive display reads.
module vram_arb
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int HOST_GAP = 8
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              hst_req,
  input  logic              hst_we,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic [7:0]        hst_wdat,
  output logic              hst_ack,
  output logic [7:0]        hst_rdat,
  output logic              hst_rvld,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  input  logic [7:0]        dsp_len,
  output logic              dsp_ack,
  output logic [7:0]        dsp_rdat,
  output logic              dsp_rvld,
  output logic              dsp_done,
  output logic              vr_cs,
  output logic              vr_we,
  output logic [ADDR_W-1:0] vr_addr,
  output logic [7:0]        vr_wdat,
  input  logic [7:0]        vr_rdat
);

  localparam logic [7:0] GAP = 8'(HOST_GAP);

  arb_st_e           state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s, vaddr_s;
  logic [7:0]        rem_r, rem_nxt_s, run_r, run_nxt_s, run_inc_s, wdat_s;
  logic              bact_r, bact_nxt_s, first_r, first_nxt_s;
  logic              cs_s, we_s, hack_s, dack_s, hpend_s, last_s;
  logic [TAG_W-1:0]  tag_s, tag_r;
  logic              rt_vld_s, rt_own_s, rt_last_s;

  // Next-state and issue decode; the run counter saturates at the gap.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    rem_nxt_s   = rem_r;
    run_nxt_s   = run_r;
    bact_nxt_s  = bact_r;
    first_nxt_s = first_r;
    cs_s        = 1'b0;
    we_s        = 1'b0;
    vaddr_s     = vr_addr;
    wdat_s      = vr_wdat;
    hack_s      = 1'b0;
    dack_s      = 1'b0;
    tag_s       = {TAG_W{1'b0}};
    hpend_s     = hst_req & ~hst_ack;
    last_s      = (rem_r == 8'd0);
    run_inc_s   = (run_r >= GAP) ? run_r : run_r + 8'd1;
    case (state_r)
      ST_IDLE: begin
        run_nxt_s = 8'd0;
        if (dsp_req && !dsp_ack) begin
          state_nxt_s = ST_DSP;
          addr_nxt_s  = dsp_addr;
          rem_nxt_s   = dsp_len;
          bact_nxt_s  = 1'b1;
          first_nxt_s = 1'b1;
        end else if (hpend_s) begin
          state_nxt_s = ST_HST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DSP: begin
        cs_s        = 1'b1;
        vaddr_s     = addr_r;
        dack_s      = first_r;
        first_nxt_s = 1'b0;
        tag_s       = mk_tag(1'b1, OWN_DISP, last_s);
        addr_nxt_s  = addr_r + ADDR_W'(1'b1);
        run_nxt_s   = run_inc_s;
        if (last_s) begin
          bact_nxt_s  = 1'b0;
          state_nxt_s = hpend_s ? ST_HST : ST_IDLE;
        end else begin
          rem_nxt_s   = rem_r - 8'd1;
          state_nxt_s = (hpend_s && (run_inc_s >= GAP)) ? ST_HST : ST_DSP;
        end
      end
      ST_HST: begin
        cs_s        = 1'b1;
        we_s        = hst_we;
        vaddr_s     = hst_addr;
        wdat_s      = hst_wdat;
        hack_s      = 1'b1;
        tag_s       = mk_tag(~hst_we, OWN_HOST, 1'b0);
        run_nxt_s   = 8'd0;
        state_nxt_s = bact_r ? ST_DSP : ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM and burst bookkeeping registers.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      rem_r   <= 8'd0;
      run_r   <= 8'd0;
      bact_r  <= 1'b0;
      first_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      rem_r   <= rem_nxt_s;
      run_r   <= run_nxt_s;
      bact_r  <= bact_nxt_s;
      first_r <= first_nxt_s;
    end
  end

  // Registered VRAM strobe, acks and the tag of the access being issued.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      vr_cs   <= 1'b0;
      vr_we   <= 1'b0;
      vr_addr <= {ADDR_W{1'b0}};
      vr_wdat <= 8'd0;
      hst_ack <= 1'b0;
      dsp_ack <= 1'b0;
      tag_r   <= {TAG_W{1'b0}};
    end else begin
      vr_cs   <= cs_s;
      vr_we   <= we_s;
      vr_addr <= vaddr_s;
      vr_wdat <= wdat_s;
      hst_ack <= hack_s;
      dsp_ack <= dack_s;
      tag_r   <= tag_s;
    end
  end

  vram_rtag #(.RD_LAT(RD_LAT)) u_rtag (
    .clk    (clk),
    .rst_x  (rst_x),
    .tag_in (tag_r),
    .vld    (rt_vld_s),
    .own    (rt_own_s),
    .last   (rt_last_s)
  );

  // Steer returning read data to its owner.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      hst_rdat <= 8'd0;
      hst_rvld <= 1'b0;
      dsp_rdat <= 8'd0;
      dsp_rvld <= 1'b0;
      dsp_done <= 1'b0;
    end else begin
      hst_rvld <= 1'b0;
      dsp_rvld <= 1'b0;
      dsp_done <= 1'b0;
      if (rt_vld_s) begin
        if (rt_own_s == OWN_DISP) begin
          dsp_rdat <= vr_rdat;
          dsp_rvld <= 1'b1;
          dsp_done <= rt_last_s;
        end else begin
          hst_rdat <= vr_rdat;
          hst_rvld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arb.sv
// Scoreboard bench for vram_arb: two instances (RD_LAT=1 and 2) share one stimulus stream,
// each with its own VRAM model and a monitor comparing bus order, read data and return latency.
module tb_vram_arb;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdat;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic        hst_req = 1'b0, hst_we = 1'b0;
  logic [15:0] hst_addr = 16'h0000;
  logic [7:0]  hst_wdat = 8'h00;
  logic        dsp_req = 1'b0;
  logic [15:0] dsp_addr = 16'h0000;
  logic [7:0]  dsp_len = 8'h00;

  logic        hst_ack_w [2];
  logic [7:0]  hst_rdat_w [2];
  logic        hst_rvld_w [2];
  logic        dsp_ack_w [2];
  logic [7:0]  dsp_rdat_w [2];
  logic        dsp_rvld_w [2];
  logic        dsp_done_w [2];
  logic        vr_cs_w [2];
  logic        vr_we_w [2];
  logic [15:0] vr_addr_w [2];
  logic [7:0]  vr_wdat_w [2];
  logic [7:0]  vr_rdat_w [2];

  bus_t        bus_q [$];
  logic [8:0]  dsp_q [$];
  logic [7:0]  hst_q [$];
  int          bidx [2];
  int          didx [2];
  int          hidx [2];
  int          dsp_cnt [2];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        ignore_data = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (RD_LAT=%0d) actual=%0h expected=%0h", nm, g + 1, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int LAT = g + 1;
    logic [7:0] mem [65536];
    bit         wr_b [65536];
    logic [7:0] rd1 = 8'h00;
    logic [7:0] rd2 = 8'h00;
    int         lat_q [$];

    vram_arb #(.ADDR_W(16), .RD_LAT(LAT), .HOST_GAP(8)) dut (
      .clk      (clk),
      .rst_x    (rst_x),
      .hst_req  (hst_req),
      .hst_we   (hst_we),
      .hst_addr (hst_addr),
      .hst_wdat (hst_wdat),
      .hst_ack  (hst_ack_w[g]),
      .hst_rdat (hst_rdat_w[g]),
      .hst_rvld (hst_rvld_w[g]),
      .dsp_req  (dsp_req),
      .dsp_addr (dsp_addr),
      .dsp_len  (dsp_len),
      .dsp_ack  (dsp_ack_w[g]),
      .dsp_rdat (dsp_rdat_w[g]),
      .dsp_rvld (dsp_rvld_w[g]),
      .dsp_done (dsp_done_w[g]),
      .vr_cs    (vr_cs_w[g]),
      .vr_we    (vr_we_w[g]),
      .vr_addr  (vr_addr_w[g]),
      .vr_wdat  (vr_wdat_w[g]),
      .vr_rdat  (vr_rdat_w[g])
    );

    // VRAM model: unwritten locations read back as pat(addr).
    always @(posedge clk) begin
      if (vr_cs_w[g] && vr_we_w[g]) begin
        mem[vr_addr_w[g]]  <= vr_wdat_w[g];
        wr_b[vr_addr_w[g]] <= 1'b1;
      end
      if (vr_cs_w[g] && !vr_we_w[g])
        rd1 <= wr_b[vr_addr_w[g]] ? mem[vr_addr_w[g]] : pat(vr_addr_w[g]);
      rd2 <= rd1;
    end
    assign vr_rdat_w[g] = (LAT == 1) ? rd1 : rd2;

    // Monitor: bus order, read-return latency, data and dsp_done.
    always @(negedge clk) begin
      if (!rst_x) begin
        lat_q.delete();
      end else begin
        if (vr_cs_w[g]) begin
          if (bidx[g] < bus_q.size()) begin
            chk("bus_we", g, 64'(vr_we_w[g]), 64'(bus_q[bidx[g]].we));
            chk("bus_addr", g, 64'(vr_addr_w[g]), 64'(bus_q[bidx[g]].addr));
            if (vr_we_w[g]) chk("bus_wdat", g, 64'(vr_wdat_w[g]), 64'(bus_q[bidx[g]].wdat));
            bidx[g]++;
          end else begin
            chk("bus_unexpected", g, 64'(vr_cs_w[g]), 64'd0);
          end
          if (!vr_we_w[g]) lat_q.push_back(cyc + LAT + 1);
        end
        if (hst_rvld_w[g]) begin
          if (ignore_data) begin
            if (lat_q.size() > 0) lat_q.delete(0);
          end else begin
            if (lat_q.size() > 0) chk("hst_latency", g, 64'(cyc), 64'(lat_q.pop_front()));
            else chk("hst_rvld_no_read", g, 64'(hst_rvld_w[g]), 64'd0);
            if (hidx[g] < hst_q.size()) begin
              chk("hst_rdat", g, 64'(hst_rdat_w[g]), 64'(hst_q[hidx[g]]));
              hidx[g]++;
            end else begin
              chk("hst_rvld_unexpected", g, 64'(hst_rvld_w[g]), 64'd0);
            end
          end
        end
        if (dsp_rvld_w[g]) begin
          dsp_cnt[g]++;
          if (ignore_data) begin
            if (lat_q.size() > 0) lat_q.delete(0);
          end else begin
            if (lat_q.size() > 0) chk("dsp_latency", g, 64'(cyc), 64'(lat_q.pop_front()));
            else chk("dsp_rvld_no_read", g, 64'(dsp_rvld_w[g]), 64'd0);
            if (didx[g] < dsp_q.size()) begin
              chk("dsp_rdat", g, 64'(dsp_rdat_w[g]), 64'(dsp_q[didx[g]][7:0]));
              chk("dsp_done", g, 64'(dsp_done_w[g]), 64'(dsp_q[didx[g]][8]));
              didx[g]++;
            end else begin
              chk("dsp_rvld_unexpected", g, 64'(dsp_rvld_w[g]), 64'd0);
            end
          end
        end else if (dsp_done_w[g]) begin
          chk("dsp_done_without_rvld", g, 64'(dsp_done_w[g]), 64'd0);
        end
      end
    end
  end

  task automatic exp_bus(input logic we, input logic [15:0] a, input logic [7:0] d);
    bus_q.push_back({we, a, d});
  endtask

  task automatic exp_dsp(input logic [15:0] a, input logic last);
    dsp_q.push_back({last, pat(a)});
  endtask

  task automatic chk_zero(input string nm);
    for (int g = 0; g < 2; g++)
      chk(nm, g, 64'({hst_ack_w[g], hst_rdat_w[g], hst_rvld_w[g], dsp_ack_w[g], dsp_rdat_w[g],
                      dsp_rvld_w[g], dsp_done_w[g], vr_cs_w[g], vr_we_w[g], vr_addr_w[g],
                      vr_wdat_w[g]}), 64'd0);
  endtask

  task automatic host_acc(input logic we, input logic [15:0] a, input logic [7:0] d, input logic drop);
    int n;
    hst_we = we; hst_addr = a; hst_wdat = d; hst_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!hst_ack_w[0] && n < 100);
    chk("hst_ack_wait", 0, 64'(hst_ack_w[0]), 64'd1);
    if (drop) hst_req = 1'b0;
  endtask

  task automatic dsp_burst(input logic [15:0] a, input logic [7:0] len);
    int n;
    dsp_addr = a; dsp_len = len; dsp_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!dsp_ack_w[0] && n < 100);
    chk("dsp_ack_wait", 0, 64'(dsp_ack_w[0]), 64'd1);
    dsp_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int rec [2];
    idle(3);
    chk_zero("reset_outputs");
    rst_x = 1'b1;
    idle(2);

    // Host write 0x55 to 0x0100, then read it back.
    exp_bus(1'b1, 16'h0100, 8'h55);
    exp_bus(1'b0, 16'h0100, 8'h00);
    hst_q.push_back(8'h55);
    host_acc(1'b1, 16'h0100, 8'h55, 1'b0);
    host_acc(1'b0, 16'h0100, 8'h00, 1'b1);
    idle(10);

    // Display and host request together: burst first, host write right after.
    for (int i = 0; i < 4; i++) begin
      exp_bus(1'b0, 16'(i), 8'h00);
      exp_dsp(16'(i), i == 3);
    end
    exp_bus(1'b1, 16'h0200, 8'h77);
    fork
      dsp_burst(16'h0000, 8'd3);
      host_acc(1'b1, 16'h0200, 8'h77, 1'b1);
    join
    idle(15);

    // 32-byte burst with the host always pending: slots after reads 8, 16, 24, 32.
    for (int i = 0; i < 32; i++) begin
      exp_bus(1'b0, 16'h1000 + 16'(i), 8'h00);
      exp_dsp(16'h1000 + 16'(i), i == 31);
      case (i)
        7:       exp_bus(1'b1, 16'h0300, 8'hA0);
        15:      exp_bus(1'b0, 16'h0300, 8'h00);
        23:      exp_bus(1'b1, 16'h0301, 8'hB1);
        31:      exp_bus(1'b0, 16'h0301, 8'h00);
        default: ;
      endcase
    end
    hst_q.push_back(8'hA0);
    hst_q.push_back(8'hB1);
    fork
      dsp_burst(16'h1000, 8'd31);
      begin
        host_acc(1'b1, 16'h0300, 8'hA0, 1'b0);
        host_acc(1'b0, 16'h0300, 8'h00, 1'b0);
        host_acc(1'b1, 16'h0301, 8'hB1, 1'b0);
        host_acc(1'b0, 16'h0301, 8'h00, 1'b1);
      end
    join
    idle(15);

    // Address wrap-around.
    exp_bus(1'b0, 16'hFFFE, 8'h00); exp_dsp(16'hFFFE, 1'b0);
    exp_bus(1'b0, 16'hFFFF, 8'h00); exp_dsp(16'hFFFF, 1'b0);
    exp_bus(1'b0, 16'h0000, 8'h00); exp_dsp(16'h0000, 1'b0);
    exp_bus(1'b0, 16'h0001, 8'h00); exp_dsp(16'h0001, 1'b1);
    dsp_burst(16'hFFFE, 8'd3);
    idle(15);

    // Reset during the 5th read of a 16-byte burst.
    ignore_data = 1'b1;
    for (int i = 0; i < 4; i++) exp_bus(1'b0, 16'h2000 + 16'(i), 8'h00);
    dsp_burst(16'h2000, 8'd15);
    idle(4);
    rst_x = 1'b0;
    #1;
    chk_zero("reset_mid_burst");
    idle(3);
    rst_x = 1'b1;
    ignore_data = 1'b0;
    rec[0] = dsp_cnt[0];
    rec[1] = dsp_cnt[1];
    idle(12);
    for (int g = 0; g < 2; g++) chk("no_rvld_after_reset", g, 64'(dsp_cnt[g]), 64'(rec[g]));

    // Fresh burst after reset.
    exp_bus(1'b0, 16'h2100, 8'h00); exp_dsp(16'h2100, 1'b0);
    exp_bus(1'b0, 16'h2101, 8'h00); exp_dsp(16'h2101, 1'b1);
    dsp_burst(16'h2100, 8'd1);
    idle(20);

    for (int g = 0; g < 2; g++) begin
      chk("bus_drained", g, 64'(bidx[g]), 64'(bus_q.size()));
      chk("dsp_drained", g, 64'(didx[g]), 64'(dsp_q.size()));
      chk("hst_drained", g, 64'(hidx[g]), 64'(hst_q.size()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
